// File: rtl/vsbuf_pkg.sv
// Shared definitions for the vsync-driven write-buffer sequencer: FSM encoding and default address map.
package vsbuf_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_VS   = 2'd1,
        WAIT_IDLE = 2'd2,
        ADVANCE   = 2'd3
    } vsbuf_state_e;

    localparam logic [31:0] VSBUF_BASE_ADDR   = 32'h0000_0000;
    localparam logic [31:0] VSBUF_FRAME_BYTES = 32'h0020_0000;
    localparam logic [15:0] VSBUF_DROP_MAX    = 16'hFFFF;

endpackage

// File: rtl/vs_edge_det.sv
// Rising-edge detector: rise_o is high in the cycle where d_i is 1 and its registered copy is 0.
module vs_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_i;
        end
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/vsbuf_wr_ctrl.sv
// Write-side frame-buffer ring sequencer: advances the buffer index on each accepted vsync rise.
// Optional frame dropping while the write DMA is busy is enabled with `define VSBUF_FRAME_DROP_EN.
module vsbuf_wr_ctrl
    import vsbuf_pkg::*;
#(
    parameter int                 BUF_LENTH   = 3,
    parameter int                 ADDR_W      = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR   = ADDR_W'(VSBUF_BASE_ADDR),
    parameter logic [ADDR_W-1:0]  FRAME_BYTES = ADDR_W'(VSBUF_FRAME_BYTES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              vs_i,
    input  logic              wr_busy_i,
    output logic [7:0]        bufn_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              frame_start_o,
    output logic [15:0]       drop_cnt_o
);

    localparam logic [7:0] LAST_BUF = 8'(BUF_LENTH - 1);

    vsbuf_state_e      state;
    logic              rise;
    logic [7:0]        bufn;
    logic [ADDR_W-1:0] addr;
    logic              frame_start;
`ifdef VSBUF_FRAME_DROP_EN
    logic [15:0]       drop_cnt;
`endif

    vs_edge_det u_vs_edge_det (
        .clk    (clk),
        .rst    (rst),
        .d_i    (vs_i),
        .rise_o (rise)
    );

    // addr is tracked incrementally so no multiplier is needed; wrap reloads BASE_ADDR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bufn        <= 8'd0;
            addr        <= BASE_ADDR;
            frame_start <= 1'b0;
`ifdef VSBUF_FRAME_DROP_EN
            drop_cnt    <= 16'd0;
`endif
        end else begin
            frame_start <= 1'b0;
            if (!en_i) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        state <= WAIT_VS;
                    end
                    WAIT_VS: begin
                        if (rise) begin
                            if (!wr_busy_i) begin
                                state <= ADVANCE;
                            end else begin
`ifdef VSBUF_FRAME_DROP_EN
                                if (drop_cnt != VSBUF_DROP_MAX) begin
                                    drop_cnt <= drop_cnt + 16'd1;
                                end
`else
                                state <= WAIT_IDLE;
`endif
                            end
                        end
                    end
                    WAIT_IDLE: begin
                        if (!wr_busy_i) begin
                            state <= ADVANCE;
                        end
                    end
                    ADVANCE: begin
                        state       <= WAIT_VS;
                        frame_start <= 1'b1;
                        if (bufn == LAST_BUF) begin
                            bufn <= 8'd0;
                            addr <= BASE_ADDR;
                        end else begin
                            bufn <= bufn + 8'd1;
                            addr <= addr + FRAME_BYTES;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bufn_o        = bufn;
    assign addr_o        = addr;
    assign frame_start_o = frame_start;
`ifdef VSBUF_FRAME_DROP_EN
    assign drop_cnt_o    = drop_cnt;
`else
    assign drop_cnt_o    = 16'd0;
`endif

endmodule
